// File: rtl/result_capture_unit_pkg.sv
// Shared constants for the result capture unit: FSM state codes and flag bit positions.
package result_capture_unit_pkg;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_ARMED     = 2'd1;
  localparam logic [1:0] ST_TRIGGERED = 2'd2;
  localparam logic [1:0] ST_FROZEN    = 2'd3;

  // Flags arrive ordered {Z,N,C,V}.
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  function automatic int entry_width(input int data_w, input int flag_w);
    return data_w + flag_w;
  endfunction

endpackage

// File: rtl/result_capture_unit_fifo.sv
// Synchronous first-word-fall-through FIFO; the head entry is visible combinationally.
module result_fifo
  import result_capture_unit_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 12
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign level   = count_q;
  assign do_pop  = pop & ~empty;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign rdata   = empty ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push && !clear) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/result_capture_unit.sv
// Captures the processor result/flags stream into a FIFO, freezing a fixed number of
// samples after a flag-pattern trigger; a host drains the FIFO over valid/ready.
module result_capture_unit
  import result_capture_unit_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int FLAG_W    = 4,
  parameter int DEPTH     = 8,
  parameter int POST_TRIG = 4,
  parameter int CNT_W     = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       arm,
  input  logic                       clear,
  input  logic [FLAG_W-1:0]          trig_mask,
  input  logic [FLAG_W-1:0]          trig_val,
  input  logic                       in_valid,
  input  logic [DATA_W-1:0]          in_result,
  input  logic [FLAG_W-1:0]          in_flags,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W+FLAG_W-1:0]   out_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic [1:0]                 state,
  output logic [CNT_W-1:0]           captured,
  output logic [CNT_W-1:0]           dropped,
  output logic                       triggered
);

  localparam int ENTRY_W = entry_width(DATA_W, FLAG_W);
  localparam int PW      = $clog2(POST_TRIG + 2);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [1:0]       state_q, state_d;
  logic [PW-1:0]    post_q, post_d;
  logic [CNT_W-1:0] captured_q, captured_d;
  logic [CNT_W-1:0] dropped_q, dropped_d;
  logic             triggered_q, triggered_d;

  logic fifo_full, fifo_empty;
  logic pop_req, offered, wr_en, drop, trig_hit;

  assign out_valid = ~fifo_empty;
  assign pop_req   = out_valid & out_ready;
  assign offered   = in_valid & ((state_q == ST_ARMED) | (state_q == ST_TRIGGERED));
  assign wr_en     = offered & (~fifo_full | pop_req);
  assign drop      = offered & fifo_full & ~pop_req;
  assign trig_hit  = offered & (state_q == ST_ARMED) & (trig_mask != '0) &
                     (((in_flags ^ trig_val) & trig_mask) == '0);

  result_fifo #(.DEPTH(DEPTH), .WIDTH(ENTRY_W)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .push  (wr_en),
    .pop   (pop_req),
    .wdata ({in_flags, in_result}),
    .rdata (out_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  always_comb begin
    state_d     = state_q;
    post_d      = post_q;
    captured_d  = captured_q;
    dropped_d   = dropped_q;
    triggered_d = triggered_q;
    if (clear) begin
      state_d     = ST_IDLE;
      post_d      = '0;
      captured_d  = '0;
      dropped_d   = '0;
      triggered_d = 1'b0;
    end else begin
      if (wr_en && captured_q != CNT_MAX) captured_d = captured_q + CNT_W'(1);
      if (drop && dropped_q != CNT_MAX)   dropped_d  = dropped_q + CNT_W'(1);
      case (state_q)
        ST_IDLE: if (arm) state_d = ST_ARMED;
        ST_ARMED: begin
          if (trig_hit) begin
            triggered_d = 1'b1;
            if (POST_TRIG == 0) begin
              state_d = ST_FROZEN;
            end else begin
              state_d = ST_TRIGGERED;
              post_d  = PW'(POST_TRIG);
            end
          end
        end
        // Dropped samples count toward the post-trigger window as well.
        ST_TRIGGERED: begin
          if (offered) begin
            post_d = post_q - PW'(1);
            if (post_q == PW'(1)) state_d = ST_FROZEN;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      post_q      <= '0;
      captured_q  <= '0;
      dropped_q   <= '0;
      triggered_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      post_q      <= post_d;
      captured_q  <= captured_d;
      dropped_q   <= dropped_d;
      triggered_q <= triggered_d;
    end
  end

  assign state     = state_q;
  assign captured  = captured_q;
  assign dropped   = dropped_q;
  assign triggered = triggered_q;

endmodule

// File: tb/tb_result_capture_unit.sv
// Scoreboard bench for result_capture_unit: directed scenarios then randomized traffic.
module tb_result_capture_unit;

  localparam int DATA_W    = 8;
  localparam int FLAG_W    = 4;
  localparam int DEPTH     = 8;
  localparam int POST_TRIG = 4;
  localparam int CNT_W     = 16;

  localparam int S_IDLE = 0;
  localparam int S_ARMED = 1;
  localparam int S_TRIG = 2;
  localparam int S_FROZEN = 3;

  logic clk;
  logic reset;
  logic arm, clear, in_valid, out_ready, out_valid, triggered;
  logic [FLAG_W-1:0] trig_mask, trig_val, in_flags;
  logic [DATA_W-1:0] in_result;
  logic [DATA_W+FLAG_W-1:0] out_data;
  logic [$clog2(DEPTH):0] level;
  logic [1:0] state;
  logic [CNT_W-1:0] captured, dropped;

  result_capture_unit #(
    .DATA_W(DATA_W), .FLAG_W(FLAG_W), .DEPTH(DEPTH), .POST_TRIG(POST_TRIG), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .arm(arm), .clear(clear),
    .trig_mask(trig_mask), .trig_val(trig_val),
    .in_valid(in_valid), .in_result(in_result), .in_flags(in_flags),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .level(level), .state(state), .captured(captured), .dropped(dropped),
    .triggered(triggered)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: FIFO contents as a queue plus counters and window state.
  logic [11:0] exp_q[$];
  int m_level, m_captured, m_dropped, m_state, m_post;
  bit m_trig;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_level = 0; m_captured = 0; m_dropped = 0; m_state = S_IDLE; m_post = 0; m_trig = 0;
  endtask

  task automatic check_status();
    chk("level", 32'(level), m_level);
    chk("captured", 32'(captured), m_captured);
    chk("dropped", 32'(dropped), m_dropped);
    chk("state", 32'(state), m_state);
    chk("triggered", 32'(triggered), 32'(m_trig));
    chk("out_valid", 32'(out_valid), 32'(m_level > 0));
  endtask

  task automatic model_step(input bit a, input bit c, input bit v,
                            input logic [7:0] r, input logic [3:0] f, input bit rdy);
    bit pop, offered, hit;
    if (c) begin
      model_reset();
      return;
    end
    pop     = (m_level > 0) && rdy;
    offered = v && (m_state == S_ARMED || m_state == S_TRIG);
    hit     = offered && m_state == S_ARMED && trig_mask != 0 &&
              ((f & trig_mask) == (trig_val & trig_mask));
    if (offered) begin
      if (m_level < DEPTH || pop) begin
        exp_q.push_back({f, r});
        m_level++;
        if (m_captured < (2**CNT_W) - 1) m_captured++;
      end else if (m_dropped < (2**CNT_W) - 1) begin
        m_dropped++;
      end
    end
    if (pop) m_level--;
    case (m_state)
      S_IDLE: if (a) m_state = S_ARMED;
      S_ARMED: if (hit) begin
        m_trig = 1;
        m_post = POST_TRIG;
        m_state = (POST_TRIG == 0) ? S_FROZEN : S_TRIG;
      end
      S_TRIG: if (offered) begin
        m_post--;
        if (m_post == 0) m_state = S_FROZEN;
      end
      default: ;
    endcase
  endtask

  // Called at posedge+1: checks the previous edge, then drives this cycle.
  task automatic cycle(input bit a, input bit c, input bit v,
                       input logic [7:0] r, input logic [3:0] f, input bit rdy);
    check_status();
    model_step(a, c, v, r, f, rdy);
    arm = a; clear = c; in_valid = v; in_result = r; in_flags = f; out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    arm = 0; clear = 0; in_valid = 0; in_result = 0; in_flags = 0; out_ready = 0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_level"}, 32'(level), 0);
    chk({tag, "_out_valid"}, 32'(out_valid), 0);
    chk({tag, "_out_data"}, 32'(out_data), 0);
    chk({tag, "_captured"}, 32'(captured), 0);
    chk({tag, "_dropped"}, 32'(dropped), 0);
    chk({tag, "_state"}, 32'(state), 0);
    chk({tag, "_triggered"}, 32'(triggered), 0);
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset = 0;
    #1;
    check_zero("async_rst");
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1;
  endtask

  // Monitor: every accepted head entry is compared against the scoreboard queue.
  always @(negedge clk) begin
    if (reset && !clear && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("sb_underflow", 32'(out_data), 32'hFFFF_FFFF);
      end else begin
        chk("out_data", 32'(out_data), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    reset = 0;
    trig_mask = 0; trig_val = 0;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    reset = 1;

    // Three samples held, then drained in order.
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 0, 1, 8'h11, 4'h0, 0);
    cycle(0, 0, 1, 8'h22, 4'h0, 0);
    cycle(0, 0, 1, 8'h33, 4'h0, 0);
    chk("lvl3", 32'(level), 3);
    chk("cap3", 32'(captured), 3);
    repeat (4) cycle(0, 0, 0, 0, 0, 1);
    cycle(0, 1, 0, 0, 0, 0);

    // Overfill, then push+pop at full.
    cycle(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) cycle(0, 0, 1, 8'h40 + 8'(i), 4'h0, 0);
    chk("full_level", 32'(level), 8);
    chk("full_cap", 32'(captured), 8);
    chk("full_drop", 32'(dropped), 2);
    cycle(0, 0, 1, 8'hAA, 4'h5, 1);
    chk("pushpop_level", 32'(level), 8);
    chk("pushpop_drop", 32'(dropped), 2);
    repeat (9) cycle(0, 0, 0, 0, 0, 1);
    chk("drain_sb", 32'(exp_q.size()), 0);
    cycle(0, 1, 0, 0, 0, 0);

    // Trigger on Z with four post samples.
    trig_mask = 4'b1000; trig_val = 4'b1000;
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 0, 1, 8'h05, 4'h0, 0);
    cycle(0, 0, 1, 8'h00, 4'h8, 0);
    for (int i = 0; i < 6; i++) begin
      cycle(0, 0, 1, 8'h60 + 8'(i), 4'($urandom_range(0, 15)), 0);
      if (i == 3) chk("frozen_after_post", 32'(state), 3);
    end
    chk("trig_sticky", 32'(triggered), 1);
    chk("trig_cap", 32'(captured), 6);

    // Clear while TRIGGERED with five entries.
    cycle(0, 1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 1, 8'h70 + 8'(i), 4'h0, 0);
    cycle(0, 0, 1, 8'h7F, 4'h8, 0);
    chk("pre_clear_state", 32'(state), 2);
    chk("pre_clear_level", 32'(level), 5);
    cycle(0, 1, 0, 0, 0, 0);
    check_zero("clear");
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 0, 1, 8'h81, 4'h1, 0);
    cycle(0, 0, 1, 8'h82, 4'h2, 0);
    apply_reset();

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      if (n % 200 == 0) begin
        trig_mask = 4'($urandom_range(0, 15));
        trig_val  = 4'($urandom_range(0, 15));
      end
      if (n % 1000 == 999) begin
        apply_reset();
      end else begin
        cycle(($urandom % 8) == 0, ($urandom % 64) == 0, ($urandom % 4) != 0,
              8'($urandom), 4'($urandom), ($urandom % 3) == 0);
      end
    end
    repeat (DEPTH + 2) cycle(0, 0, 0, 0, 0, 1);
    chk("final_sb_empty", 32'(exp_q.size()), 0);
    chk("final_level", 32'(level), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
